// File: rtl/controlador_bomba.sv
// -----------------------------------------------------------------------------
// controlador_bomba
//
// Game-sequencing controller for the bomb-defusal design. A start press arms
// the bomb and loads the countdown; each enter press is turned into exactly one
// compare request towards the password comparator. Wrong answers are counted
// and cost PENALIDADE seconds each; the controller ends in DESARMADA (defused)
// or EXPLODIDA (exploded) and waits there for a new start.
//
// Parameters:
//   CLK_HZ         clock cycles per countdown second
//   TEMPO_INICIAL  seconds loaded on arm (1..127)
//   MAX_ERROS      wrong attempts that cause explosion (1..3)
//   PENALIDADE     seconds subtracted per wrong attempt (0..127)
//
// Ports:
//   clk            rising-edge clock
//   rst            asynchronous active-high reset
//   start          arm/restart button level (acts on rising edge)
//   enter          submit button level (acts on rising edge)
//   cmp_done       one-cycle pulse, comparator result valid
//   cmp_match      comparator result, sampled only with cmp_done
//   cmp_req        one-cycle compare request to the comparator
//   estado         0 IDLE, 1 ARMADO, 2 VERIFICA, 3 DESARMADA, 4 EXPLODIDA
//   tempo_restante seconds left
//   erros          wrong attempts so far
//   vitoria        high while in DESARMADA
//   explodiu       high while in EXPLODIDA
// -----------------------------------------------------------------------------
module controlador_bomba #(
  parameter int CLK_HZ        = 50_000_000,
  parameter int TEMPO_INICIAL = 60,
  parameter int MAX_ERROS     = 3,
  parameter int PENALIDADE    = 5
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       enter,
  input  logic       cmp_done,
  input  logic       cmp_match,
  output logic       cmp_req,
  output logic [2:0] estado,
  output logic [6:0] tempo_restante,
  output logic [1:0] erros,
  output logic       vitoria,
  output logic       explodiu
);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    ARMADO    = 3'd1,
    VERIFICA  = 3'd2,
    DESARMADA = 3'd3,
    EXPLODIDA = 3'd4
  } estado_t;

  localparam int            PW      = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
  localparam logic [PW-1:0] PRE_MAX = PW'(CLK_HZ - 1);
  localparam logic [6:0]    T_INI   = 7'(TEMPO_INICIAL);
  localparam logic [7:0]    PEN     = 8'(PENALIDADE);
  localparam logic [2:0]    ERR_MAX = 3'(MAX_ERROS);

  // State registers
  estado_t       estado_q;
  logic [PW-1:0] prescaler_q;
  logic          start_q;
  logic          enter_q;

  // Next-state values
  estado_t       estado_nxt;
  logic [PW-1:0] prescaler_nxt;
  logic [6:0]    tempo_nxt;
  logic [1:0]    erros_nxt;
  logic          cmp_req_nxt;

  // Combinational helpers
  logic       start_edge;
  logic       enter_edge;
  logic       counting;
  logic       tick;
  logic [6:0] tempo_tick;
  logic [6:0] tempo_pen;
  logic [2:0] erros_inc;

  assign start_edge = start & ~start_q;
  assign enter_edge = enter & ~enter_q;
  assign counting   = (estado_q == ARMADO) || (estado_q == VERIFICA);
  assign tick       = counting && (prescaler_q == PRE_MAX);

  // Value of the timer after this cycle's tick (never below zero).
  assign tempo_tick = (tick && (tempo_restante != 7'd0)) ? tempo_restante - 7'd1
                                                         : tempo_restante;

  // Penalty computed one bit wider so the saturation test cannot wrap.
  assign tempo_pen  = ({1'b0, tempo_tick} <= PEN) ? 7'd0
                                                  : 7'({1'b0, tempo_tick} - PEN);

  assign erros_inc  = {1'b0, erros} + 3'd1;

  // NOTE: every output of this block gets a default before any branch, so no
  // path can leave a signal unassigned and infer a latch.
  always_comb begin
    estado_nxt    = estado_q;
    tempo_nxt     = tempo_restante;
    erros_nxt     = erros;
    cmp_req_nxt   = 1'b0;
    prescaler_nxt = '0;

    if (counting) begin
      prescaler_nxt = tick ? '0 : prescaler_q + PW'(1);
    end

    unique case (estado_q)
      IDLE: begin
        if (start_edge) begin
          estado_nxt    = ARMADO;
          tempo_nxt     = T_INI;
          erros_nxt     = 2'd0;
          prescaler_nxt = '0;
        end
      end

      ARMADO: begin
        tempo_nxt = tempo_tick;
        // Reaching zero on a tick beats a simultaneous enter press.
        if (tick && (tempo_tick == 7'd0)) begin
          estado_nxt = EXPLODIDA;
        end else if (enter_edge) begin
          estado_nxt  = VERIFICA;
          cmp_req_nxt = 1'b1;
        end
      end

      VERIFICA: begin
        tempo_nxt = tempo_tick;
        if (cmp_done) begin
          if (cmp_match) begin
            // A correct answer wins even against a tick reaching zero; the
            // displayed time freezes at its pre-tick value.
            estado_nxt = DESARMADA;
            tempo_nxt  = tempo_restante;
          end else begin
            erros_nxt = erros_inc[1:0];
            if (erros_inc == ERR_MAX) begin
              estado_nxt = EXPLODIDA;
            end else begin
              tempo_nxt  = tempo_pen;
              estado_nxt = (tempo_pen == 7'd0) ? EXPLODIDA : ARMADO;
            end
          end
        end else if (tick && (tempo_tick == 7'd0)) begin
          estado_nxt = EXPLODIDA;
        end
      end

      DESARMADA, EXPLODIDA: begin
        if (start_edge) begin
          estado_nxt    = ARMADO;
          tempo_nxt     = T_INI;
          erros_nxt     = 2'd0;
          prescaler_nxt = '0;
        end
      end

      default: begin
        estado_nxt = IDLE;
      end
    endcase
  end

  // NOTE: state is updated with non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      estado_q       <= IDLE;
      prescaler_q    <= '0;
      tempo_restante <= T_INI;
      erros          <= 2'd0;
      cmp_req        <= 1'b0;
      vitoria        <= 1'b0;
      explodiu       <= 1'b0;
      // Edge detectors come out of reset "high" so a button held through
      // reset does not register as a press.
      start_q        <= 1'b1;
      enter_q        <= 1'b1;
    end else begin
      estado_q       <= estado_nxt;
      prescaler_q    <= prescaler_nxt;
      tempo_restante <= tempo_nxt;
      erros          <= erros_nxt;
      cmp_req        <= cmp_req_nxt;
      vitoria        <= (estado_nxt == DESARMADA);
      explodiu       <= (estado_nxt == EXPLODIDA);
      start_q        <= start;
      enter_q        <= enter;
    end
  end

  assign estado = estado_q;

endmodule

// File: tb/tb_controlador_bomba.sv
// -----------------------------------------------------------------------------
// tb_controlador_bomba
//
// Self-checking bench for controlador_bomba. The main instance uses
// CLK_HZ=4, TEMPO_INICIAL=5, MAX_ERROS=3, PENALIDADE=2 and is driven from a
// table of {inputs, cycles, expected outputs} records; expectations are queued
// when a record is driven and popped when its cycles have elapsed. A second
// instance with a slower prescaler (CLK_HZ=16) shares the inputs and is used
// for the three-miss sequence, which needs more than one tick period of room.
// -----------------------------------------------------------------------------
module tb_controlador_bomba;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic       enter;
  logic       cmp_done;
  logic       cmp_match;

  logic       cmp_req,   cmp_req_b;
  logic [2:0] estado,    estado_b;
  logic [6:0] tempo,     tempo_b;
  logic [1:0] erros,     erros_b;
  logic       vitoria,   vitoria_b;
  logic       explodiu,  explodiu_b;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  controlador_bomba #(
    .CLK_HZ(4), .TEMPO_INICIAL(5), .MAX_ERROS(3), .PENALIDADE(2)
  ) u_dut (
    .clk(clk), .rst(rst), .start(start), .enter(enter),
    .cmp_done(cmp_done), .cmp_match(cmp_match), .cmp_req(cmp_req),
    .estado(estado), .tempo_restante(tempo), .erros(erros),
    .vitoria(vitoria), .explodiu(explodiu)
  );

  controlador_bomba #(
    .CLK_HZ(16), .TEMPO_INICIAL(5), .MAX_ERROS(3), .PENALIDADE(2)
  ) u_dut_lento (
    .clk(clk), .rst(rst), .start(start), .enter(enter),
    .cmp_done(cmp_done), .cmp_match(cmp_match), .cmp_req(cmp_req_b),
    .estado(estado_b), .tempo_restante(tempo_b), .erros(erros_b),
    .vitoria(vitoria_b), .explodiu(explodiu_b)
  );

  typedef struct {
    string      nome;
    logic       start, enter, done, match;
    int         ncyc;
    logic [2:0] e_estado;
    logic [6:0] e_tempo;
    logic       chk_tempo;
    logic [1:0] e_erros;
    logic       e_req, e_vit, e_expl;
  } vec_t;

  vec_t vecs[$];
  vec_t exp_q[$];

  task automatic check(input string nome, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d", nome, act, exp);
    end
  endtask

  task automatic add(input string nome, input logic s, e, d, m, input int n,
                     input logic [2:0] est, input logic [6:0] t, input logic ct,
                     input logic [1:0] err, input logic req, vit, expl);
    vec_t v;
    v.nome = nome; v.start = s; v.enter = e; v.done = d; v.match = m;
    v.ncyc = n; v.e_estado = est; v.e_tempo = t; v.chk_tempo = ct;
    v.e_erros = err; v.e_req = req; v.e_vit = vit; v.e_expl = expl;
    vecs.push_back(v);
  endtask

  // Drive one record: inputs for the first cycle, then idle for the rest.
  task automatic apply(input vec_t v);
    vec_t e;
    start = v.start; enter = v.enter; cmp_done = v.done; cmp_match = v.match;
    exp_q.push_back(v);
    for (int c = 0; c < v.ncyc; c++) begin
      @(posedge clk); #1;
      start = 1'b0; enter = 1'b0; cmp_done = 1'b0; cmp_match = 1'b0;
    end
    @(negedge clk);
    e = exp_q.pop_front();
    check({e.nome, ".estado"}, int'(estado), int'(e.e_estado));
    if (e.chk_tempo) check({e.nome, ".tempo"}, int'(tempo), int'(e.e_tempo));
    check({e.nome, ".erros"},    int'(erros),    int'(e.e_erros));
    check({e.nome, ".cmp_req"},  int'(cmp_req),  int'(e.e_req));
    check({e.nome, ".vitoria"},  int'(vitoria),  int'(e.e_vit));
    check({e.nome, ".explodiu"}, int'(explodiu), int'(e.e_expl));
    check({e.nome, ".exclusive"}, int'(vitoria & explodiu), 0);
  endtask

  // One cycle of hand stimulus; enter keeps its level afterwards.
  task automatic cyc(input logic s, e, d, m);
    start = s; enter = e; cmp_done = d; cmp_match = m;
    @(posedge clk); #1;
    start = 1'b0; cmp_done = 1'b0; cmp_match = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1; start = 1'b0; enter = 1'b0; cmp_done = 1'b0; cmp_match = 1'b0;

    //   name             st en dn mt  n  est t  ct er rq vt ex
    add("rst_idle",       0, 0, 0, 0,  1, 0, 5, 1, 0, 0, 0, 0);
    // Free-running countdown to explosion.
    add("arm",            1, 0, 0, 0,  1, 1, 5, 1, 0, 0, 0, 0);
    add("pre_tick",       0, 0, 0, 0,  3, 1, 5, 1, 0, 0, 0, 0);
    add("tick1",          0, 0, 0, 0,  1, 1, 4, 1, 0, 0, 0, 0);
    add("tick2",          0, 0, 0, 0,  4, 1, 3, 1, 0, 0, 0, 0);
    add("tick3",          0, 0, 0, 0,  4, 1, 2, 1, 0, 0, 0, 0);
    add("tick4",          0, 0, 0, 0,  4, 1, 1, 1, 0, 0, 0, 0);
    add("pre_zero",       0, 0, 0, 0,  3, 1, 1, 1, 0, 0, 0, 0);
    add("boom",           0, 0, 0, 0,  1, 4, 0, 1, 0, 0, 0, 1);
    add("enter_boom",     0, 1, 0, 0,  1, 4, 0, 1, 0, 0, 0, 1);
    add("boom_hold",      0, 0, 0, 0,  2, 4, 0, 1, 0, 0, 0, 1);
    // Correct password at t=5.
    add("rearm",          1, 0, 0, 0,  1, 1, 5, 1, 0, 0, 0, 0);
    add("enter_req",      0, 1, 0, 0,  1, 2, 5, 1, 0, 1, 0, 0);
    add("start_in_verif", 1, 0, 0, 0,  1, 2, 5, 1, 0, 0, 0, 0);
    add("match",          0, 0, 1, 1,  1, 3, 5, 1, 0, 0, 1, 0);
    add("win_hold",       0, 0, 0, 0,  8, 3, 5, 1, 0, 0, 1, 0);
    add("win_enter",      0, 1, 0, 0,  1, 3, 5, 1, 0, 0, 1, 0);
    add("win_done_ign",   0, 0, 1, 0,  1, 3, 5, 1, 0, 0, 1, 0);
    // Miss at t=1 coinciding with the tick: saturates to 0.
    add("rearm2",         1, 0, 0, 0,  1, 1, 5, 1, 0, 0, 0, 0);
    add("to_t1",          0, 0, 0, 0, 16, 1, 1, 1, 0, 0, 0, 0);
    add("enter_t1",       0, 1, 0, 0,  1, 2, 1, 1, 0, 1, 0, 0);
    add("verif_wait",     0, 0, 0, 0,  1, 2, 1, 1, 0, 0, 0, 0);
    add("enter_ignored",  0, 1, 0, 0,  1, 2, 1, 1, 0, 0, 0, 0);
    add("miss_tick_sat",  0, 0, 1, 0,  1, 4, 0, 1, 1, 0, 0, 1);
    // Match coinciding with the tick that would reach 0: defused wins.
    add("rearm3",         1, 0, 0, 0,  1, 1, 5, 1, 0, 0, 0, 0);
    add("to_t1b",         0, 0, 0, 0, 16, 1, 1, 1, 0, 0, 0, 0);
    add("enter_t1b",      0, 1, 0, 0,  1, 2, 1, 1, 0, 1, 0, 0);
    add("verif_wait2",    0, 0, 0, 0,  2, 2, 1, 1, 0, 0, 0, 0);
    add("match_tick",     0, 0, 1, 1,  1, 3, 0, 0, 0, 0, 1, 0);
    // Enter on the cycle the tick reaches 0: explosion, no request.
    add("rearm4",         1, 0, 0, 0,  1, 1, 5, 1, 0, 0, 0, 0);
    add("to_t1c",         0, 0, 0, 0, 19, 1, 1, 1, 0, 0, 0, 0);
    add("enter_on_boom",  0, 1, 0, 0,  1, 4, 0, 1, 0, 0, 0, 1);
    add("no_req",         0, 0, 0, 0,  1, 4, 0, 1, 0, 0, 0, 1);

    // Reset values while reset is held.
    @(negedge clk);
    @(negedge clk);
    check("rst.estado",   int'(estado),   0);
    check("rst.tempo",    int'(tempo),    5);
    check("rst.erros",    int'(erros),    0);
    check("rst.cmp_req",  int'(cmp_req),  0);
    check("rst.vitoria",  int'(vitoria),  0);
    check("rst.explodiu", int'(explodiu), 0);
    rst = 1'b0;

    foreach (vecs[i]) apply(vecs[i]);

    // Enter held high through reset release gives no edge.
    enter = 1'b1; rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      cyc(1'b0, 1'b1, 1'b0, 1'b0);
      check("held_enter.cmp_req", int'(cmp_req), 0);
      check("held_enter.estado",  int'(estado),  0);
    end
    cyc(1'b1, 1'b1, 1'b0, 1'b0);
    check("held_arm.estado",  int'(estado),  1);
    check("held_arm.cmp_req", int'(cmp_req), 0);
    cyc(1'b0, 1'b1, 1'b0, 1'b0);
    check("held_still.estado",  int'(estado),  1);
    check("held_still.cmp_req", int'(cmp_req), 0);
    cyc(1'b0, 1'b0, 1'b0, 1'b0);
    cyc(1'b0, 1'b1, 1'b0, 1'b0);
    check("verif_pre_rst.estado",  int'(estado),  2);
    check("verif_pre_rst.cmp_req", int'(cmp_req), 1);

    // Asynchronous reset in VERIFICA, observed before any clock edge.
    rst = 1'b1;
    #1;
    check("async_rst.estado",   int'(estado),   0);
    check("async_rst.tempo",    int'(tempo),    5);
    check("async_rst.erros",    int'(erros),    0);
    check("async_rst.cmp_req",  int'(cmp_req),  0);
    check("async_rst.vitoria",  int'(vitoria),  0);
    check("async_rst.explodiu", int'(explodiu), 0);
    @(negedge clk);
    rst = 1'b0; enter = 1'b0;

    // Three consecutive misses on the slow instance (no tick in between).
    cyc(1'b0, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 1'b0, 1'b0, 1'b0);
    check("b_arm.estado", int'(estado_b), 1);
    check("b_arm.tempo",  int'(tempo_b),  5);
    cyc(1'b0, 1'b1, 1'b0, 1'b0);
    check("b_req1.cmp_req", int'(cmp_req_b), 1);
    cyc(1'b0, 1'b0, 1'b1, 1'b0);
    check("b_miss1.estado", int'(estado_b), 1);
    check("b_miss1.tempo",  int'(tempo_b),  3);
    check("b_miss1.erros",  int'(erros_b),  1);
    cyc(1'b0, 1'b1, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 1'b1, 1'b0);
    check("b_miss2.estado", int'(estado_b), 1);
    check("b_miss2.tempo",  int'(tempo_b),  1);
    check("b_miss2.erros",  int'(erros_b),  2);
    cyc(1'b0, 1'b1, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 1'b1, 1'b0);
    check("b_miss3.estado",   int'(estado_b),   4);
    check("b_miss3.erros",    int'(erros_b),    3);
    check("b_miss3.explodiu", int'(explodiu_b), 1);
    check("b_miss3.vitoria",  int'(vitoria_b),  0);
    cyc(1'b1, 1'b0, 1'b0, 1'b0);
    check("b_rearm.estado",   int'(estado_b),   1);
    check("b_rearm.tempo",    int'(tempo_b),    5);
    check("b_rearm.erros",    int'(erros_b),    0);
    check("b_rearm.explodiu", int'(explodiu_b), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/controlador_bomba.md
# controlador_bomba

Game-sequencing controller for the bomb-defusal design. It arms the bomb on `start` and runs a one-second countdown. Each `enter` press becomes a single compare request to the password comparator. The controller counts wrong attempts, applies a time penalty per miss, and drives the terminal defused/exploded outcomes. It sits between the user buttons/timebase and the comparator, and feeds the display logic.

## Interface
Parameters:
- `CLK_HZ`, 50_000_000: clock cycles per countdown second.
- `TEMPO_INICIAL`, 60: seconds loaded on arm; range 1..127.
- `MAX_ERROS`, 3: wrong attempts that cause explosion; range 1..3.
- `PENALIDADE`, 5: seconds subtracted per wrong attempt; range 0..127.

Ports:
- `clk` input 1: single clock, rising edge.
- `rst` input 1: asynchronous, active-high reset.
- `start` input 1: arm/restart button, synchronous level; acts on rising edge.
- `enter` input 1: submit button, synchronous level; acts on rising edge.
- `cmp_done` input 1: one-cycle pulse, comparator result valid.
- `cmp_match` input 1: 1 = attempt equals password; sampled only with `cmp_done`.
- `cmp_req` output 1: one-cycle compare request to the comparator.
- `estado` output 3: 0 IDLE, 1 ARMADO, 2 VERIFICA, 3 DESARMADA, 4 EXPLODIDA.
- `tempo_restante` output 7: seconds left.
- `erros` output 2: wrong attempts so far.
- `vitoria` output 1: high while in DESARMADA.
- `explodiu` output 1: high while in EXPLODIDA.

## Operation
- All outputs are registered.
- Edge detectors: `start_q` and `enter_q` reset to 1, so a button held through reset gives no edge.
- Prescaler: counts 0..CLK_HZ-1 only in ARMADO and VERIFICA. Wrapping from CLK_HZ-1 to 0 generates `tick`.
- Prescaler clears on every entry to ARMADO from IDLE, DESARMADA or EXPLODIDA.
- IDLE: on `start` edge, go to ARMADO. Load `tempo_restante`=TEMPO_INICIAL, `erros`=0, prescaler=0.
- ARMADO:
  - `tick`: decrement `tempo_restante`. If the result is 0, go to EXPLODIDA.
  - `enter` edge with no explosion this cycle: go to VERIFICA and pulse `cmp_req` on the next cycle.
- VERIFICA:
  - `enter` and `start` edges are ignored.
  - The timer keeps running. If `tick` brings `tempo_restante` to 0 with no `cmp_done`, go to EXPLODIDA.
  - `cmp_done` with `cmp_match`=1: go to DESARMADA; the timer freezes.
  - `cmp_done` with `cmp_match`=0:
    - `erros`+1 == MAX_ERROS: go to EXPLODIDA.
    - Otherwise: `erros`+1, and `tempo_restante` = max(0, t − PENALIDADE), where t is the value after this cycle's tick. A result of 0 goes to EXPLODIDA; otherwise go to ARMADO.
- DESARMADA / EXPLODIDA:
  - Terminal states. `tempo_restante` and `erros` hold.
  - A `start` edge re-arms directly to ARMADO with a fresh load.
- Arithmetic: the penalty subtraction is done at 8 bits and saturates at 0; `tempo_restante` never wraps.
- Simultaneous events:
  - `tick` reaching 0 in the same cycle as `cmp_done`+match: defused wins.
  - `tick` with `cmp_done`+mismatch: decrement first, then apply penalty.
  - `enter` edge in the same cycle a `tick` reaches 0 in ARMADO: explosion wins and no `cmp_req` is issued.
- `cmp_done` outside VERIFICA is ignored.
- Reset values: `estado`=IDLE, `tempo_restante`=TEMPO_INICIAL, `erros`=0, `cmp_req`=0, `vitoria`=0, `explodiu`=0, prescaler=0.
- Reset mid-operation returns to these values immediately, asynchronously.

## Timing
- `enter` edge seen in cycle N (ARMADO): `estado`=VERIFICA and `cmp_req`=1 in cycle N+1. `cmp_req`=0 from N+2.
- There is exactly one `cmp_req` per VERIFICA visit. Comparator latency is unbounded; the controller waits in VERIFICA.
- `cmp_done` in cycle M: new `estado`, `erros`, `tempo_restante`, `vitoria` and `explodiu` are visible in M+1.
- `start` edge in cycle N: ARMADO with loaded values in N+1. The first `tick` occurs CLK_HZ cycles later.
- Countdown from arm to explosion with no input: TEMPO_INICIAL×CLK_HZ cycles after entering ARMADO.
- `vitoria` and `explodiu` are never high together.

## Test plan
Bench parameters: CLK_HZ=4, TEMPO_INICIAL=5, MAX_ERROS=3, PENALIDADE=2.
- Reset, then `start` pulse, no enter:
  - `tempo_restante` steps 5→4→3→2→1→0 every 4 cycles.
  - `estado`=4 and `explodiu`=1 20 cycles after arming.
  - Subsequent `enter` yields no `cmp_req`.
- Arm, `enter` at t=5, `cmp_done`+match 3 cycles later:
  - One `cmp_req` pulse.
  - `estado`=3, `vitoria`=1, `tempo_restante` frozen at 5.
  - Further ticks/enters have no effect.
- Arm, one miss at t=5: `erros`=1, `tempo_restante`=3, back to ARMADO. A second miss at t=3 gives `tempo_restante`=1 and `erros`=2. A third miss gives EXPLODIDA with `erros`=3.
- Miss at t=1 with `cmp_done` coinciding with a `tick`: saturates to 0, `estado`=4.
- `tick` to 0 coincident with `cmp_done`+match: `estado`=3.
- Hold `enter` high across reset release: no `cmp_req`. Assert `rst` during VERIFICA: all outputs return to reset values the same cycle. A later `start` from EXPLODIDA re-arms with t=5, `erros`=0.
